// File: rtl/pattern_seq_detector_if.sv
// Configuration, serial data and status bundle of the pattern_seq_detector block.
// The block uses the slave modport, and whatever drives it uses the master modport.
interface pattern_seq_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               cnt_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din, cnt_clr,
    input  detected, match_count, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din, cnt_clr,
    output detected, match_count, cfg_err
  );
endinterface

// File: rtl/pattern_seq_detector.sv
// Serial bit-pattern detector with a pattern, length and overlap mode loaded at run time.
// It also provides a saturating match counter and a sticky flag for rejected loads.
module pattern_seq_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 RST_LEN     = 4,
  parameter logic               RST_OVERLAP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pattern_seq_detector_if.slave  bus
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [MAX_LEN-1:0] hist_r, hist_nxt_s, shifted_s;
  logic [LEN_W-1:0]   fill_r, fill_nxt_s, fill_inc_s;
  logic [MAX_LEN-1:0] pat_r, pat_nxt_s;
  logic [LEN_W-1:0]   len_r, len_nxt_s;
  logic               ovl_r, ovl_nxt_s;
  logic               detected_r, detected_nxt_s;
  logic [CNT_W-1:0]   count_r, count_nxt_s;
  logic               cfg_err_r, cfg_err_nxt_s;
  logic               accept_s, cfg_ok_s, bits_eq_s, match_s;

  // Match evaluation on the history as it will be once the current bit is shifted in.
  always_comb begin
    shifted_s  = {hist_r[MAX_LEN-2:0], bus.din};
    fill_inc_s = (fill_r >= LEN_MAX) ? LEN_MAX : (fill_r + LEN_ONE);
    accept_s   = bus.din_valid & ~bus.cfg_load;
    cfg_ok_s   = (bus.cfg_len >= LEN_ONE) && (bus.cfg_len <= LEN_MAX);
    bits_eq_s  = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      // Pattern bits at or above len never take part in the compare.
      if ((LEN_W'(i) < len_r) && (shifted_s[i] != pat_r[i])) begin
        bits_eq_s = 1'b0;
      end else begin
        bits_eq_s = bits_eq_s;
      end
    end
    match_s = accept_s & (fill_inc_s >= len_r) & bits_eq_s;
  end

  // Next-state selection for the history, the configuration and the status outputs.
  always_comb begin
    hist_nxt_s     = hist_r;
    fill_nxt_s     = fill_r;
    pat_nxt_s      = pat_r;
    len_nxt_s      = len_r;
    ovl_nxt_s      = ovl_r;
    cfg_err_nxt_s  = cfg_err_r;
    count_nxt_s    = count_r;
    detected_nxt_s = match_s;

    if (bus.cfg_load) begin
      fill_nxt_s = LEN_ZERO;
      if (cfg_ok_s) begin
        pat_nxt_s     = bus.cfg_pattern;
        len_nxt_s     = bus.cfg_len;
        ovl_nxt_s     = bus.cfg_overlap;
        cfg_err_nxt_s = 1'b0;
      end else begin
        cfg_err_nxt_s = 1'b1;
      end
    end else if (accept_s) begin
      hist_nxt_s = shifted_s;
      // In non-overlap mode a match empties the history so that the next match needs len fresh bits.
      if (match_s && !ovl_r) begin
        fill_nxt_s = LEN_ZERO;
      end else begin
        fill_nxt_s = fill_inc_s;
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end

    if (bus.cnt_clr) begin
      count_nxt_s = CNT_ZERO;
    end else if (match_s && (count_r != CNT_ONES)) begin
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r     <= {MAX_LEN{1'b0}};
      fill_r     <= LEN_ZERO;
      pat_r      <= RST_PATTERN;
      len_r      <= LEN_W'(RST_LEN);
      ovl_r      <= RST_OVERLAP;
      detected_r <= 1'b0;
      count_r    <= CNT_ZERO;
      cfg_err_r  <= 1'b0;
    end else begin
      hist_r     <= hist_nxt_s;
      fill_r     <= fill_nxt_s;
      pat_r      <= pat_nxt_s;
      len_r      <= len_nxt_s;
      ovl_r      <= ovl_nxt_s;
      detected_r <= detected_nxt_s;
      count_r    <= count_nxt_s;
      cfg_err_r  <= cfg_err_nxt_s;
    end
  end

  assign bus.detected    = detected_r;
  assign bus.match_count = count_r;
  assign bus.cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Self-checking bench for pattern_seq_detector. Two instances (8-bit and 2-bit counter) share one
// stimulus stream. A queue-based reference model predicts every output on every cycle.
module tb_pattern_seq_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load, cfg_overlap, din_valid, din, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  pattern_seq_detector_if #(.CNT_W(8)) b0 ();
  pattern_seq_detector_if #(.CNT_W(2)) b1 ();

  assign b0.cfg_load = cfg_load;       assign b1.cfg_load = cfg_load;
  assign b0.cfg_pattern = cfg_pattern; assign b1.cfg_pattern = cfg_pattern;
  assign b0.cfg_len = cfg_len;         assign b1.cfg_len = cfg_len;
  assign b0.cfg_overlap = cfg_overlap; assign b1.cfg_overlap = cfg_overlap;
  assign b0.din_valid = din_valid;     assign b1.din_valid = din_valid;
  assign b0.din = din;                 assign b1.din = din;
  assign b0.cnt_clr = cnt_clr;         assign b1.cnt_clr = cnt_clr;

  pattern_seq_detector #(.CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  pattern_seq_detector #(.CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {b0.detected, b1.detected, b0.match_count, b1.match_count, b0.cfg_err, b1.cfg_err};

  int tests = 0;
  int fails = 0;

  // Reference model: the accepted bits since the last restart, newest at the back.
  bit          q[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  bit          exp_det, exp_err;
  int          exp_c0, exp_c1;
  logic [13:0] expv;

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
    exp_det = 1'b0; exp_err = 1'b0; exp_c0 = 0; exp_c1 = 0;
    expv = 14'd0;
  endtask

  task automatic cycle(input logic ld, input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic v, input logic d, input logic clr);
    bit hit;
    cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    din_valid = v; din = d; cnt_clr = clr;
    @(posedge clk);
    hit = 1'b0;
    if (ld) begin
      q.delete();
      if (l >= 4'd1 && l <= 4'd8) begin
        m_pat = p; m_len = int'(l); m_ovl = o; exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
    end else if (v) begin
      q.push_back(d);
      if (q.size() > 8) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size()-1-k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) q.delete();
    end
    if (clr) begin
      exp_c0 = 0; exp_c1 = 0;
    end else if (hit) begin
      if (exp_c0 < 255) exp_c0++;
      if (exp_c1 < 3) exp_c1++;
    end
    exp_det = hit;
    expv = {exp_det, exp_det, 8'(exp_c0), 2'(exp_c1), exp_err, exp_err};
    #1;
  endtask

  task automatic send_bit(input logic d, input logic clr);
    cycle(1'b0, 8'($urandom), 4'($urandom), 1'($urandom), 1'b1, d, clr);
  endtask

  task automatic idle();
    cycle(1'b0, 8'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cycle(1'b1, p, l, o, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_load = 1'b0; cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs !== 14'd0) begin fails++; $display("FAIL reset_outputs: got %h expected %h", obs, 14'd0); end
    rst_n = 1'b1;
    idle();
    tests++;
    if (obs !== expv) begin fails++; $display("FAIL reset_idle: got %h expected %h", obs, expv); end
  endtask

  task automatic test_default_1011();
    logic [11:0] s;
    s = 12'b1011_0100_1011;
    for (int i = 0; i < 12; i++) begin
      send_bit(s[11-i], 1'b0);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL default_model bit%0d: got %h expected %h", i+1, obs, expv); end
      tests++;
      if (b0.detected !== ((i == 3) || (i == 11))) begin
        fails++; $display("FAIL default_pulse bit%0d: got %b", i+1, b0.detected);
      end
    end
    tests++;
    if (b0.match_count !== 8'd2) begin fails++; $display("FAIL default_count: got %0d expected 2", b0.match_count); end
  endtask

  task automatic test_load_overlap();
    logic [4:0] s;
    s = 5'b10101;
    for (int pass = 0; pass < 2; pass++) begin
      load(8'b0000_0101, 4'd3, (pass == 0));
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL load101 pass%0d: got %h expected %h", pass, obs, expv); end
      for (int i = 0; i < 5; i++) begin
        send_bit(s[4-i], 1'b0);
        tests++;
        if (obs !== expv) begin fails++; $display("FAIL ovl_model pass%0d bit%0d: got %h expected %h", pass, i+1, obs, expv); end
        tests++;
        if (b0.detected !== ((i == 2) || (pass == 0 && i == 4))) begin
          fails++; $display("FAIL ovl_pulse pass%0d bit%0d: got %b", pass, i+1, b0.detected);
        end
      end
      tests++;
      if (b0.match_count !== ((pass == 0) ? 8'd4 : 8'd5)) begin
        fails++; $display("FAIL ovl_count pass%0d: got %0d", pass, b0.match_count);
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic [11:0] s;
    s = 12'b1011_0100_1011;
    load(8'b0000_1011, 4'd4, 1'b1);
    for (int i = 0; i < 12; i++) begin
      send_bit(s[11-i], 1'b0);
      tests++;
      if (b0.detected !== ((i == 3) || (i == 11)) || obs !== expv) begin
        fails++; $display("FAIL gaps_bit%0d: got %h expected %h", i+1, obs, expv);
      end
      idle();
      tests++;
      if (b0.detected !== 1'b0 || obs !== expv) begin
        fails++; $display("FAIL gaps_idle%0d: got %h expected %h", i+1, obs, expv);
      end
    end
    tests++;
    if (b0.match_count !== 8'd7) begin fails++; $display("FAIL gaps_count: got %0d expected 7", b0.match_count); end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'b1111_1111, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, (i == 4));
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL sat_model bit%0d: got %h expected %h", i+1, obs, expv); end
      tests++;
      if (b1.detected !== 1'b1 || b1.match_count !== ((i == 4) ? 2'd0 : ((i >= 2) ? 2'd3 : 2'(i+1)))) begin
        fails++; $display("FAIL sat_count bit%0d: got det=%b cnt=%0d", i+1, b1.detected, b1.match_count);
      end
    end
  endtask

  task automatic test_bad_cfg();
    logic [11:0] s;
    s = 12'b1011_0100_1011;
    load(8'b0000_1011, 4'd4, 1'b1);
    load(8'b1111_1111, 4'd0, 1'b0);
    tests++;
    if (b0.cfg_err !== 1'b1 || obs !== expv) begin fails++; $display("FAIL bad_len0: got %h expected %h", obs, expv); end
    load(8'b0000_0000, 4'd9, 1'b0);
    tests++;
    if (b1.cfg_err !== 1'b1 || obs !== expv) begin fails++; $display("FAIL bad_len9: got %h expected %h", obs, expv); end
    for (int i = 0; i < 12; i++) begin
      send_bit(s[11-i], 1'b0);
      tests++;
      if (b0.detected !== ((i == 3) || (i == 11)) || obs !== expv) begin
        fails++; $display("FAIL bad_keep bit%0d: got %h expected %h", i+1, obs, expv);
      end
    end
    tests++;
    if (b0.match_count !== 8'd2) begin fails++; $display("FAIL bad_count: got %0d expected 2", b0.match_count); end
    load(8'b0000_0110, 4'd3, 1'b0);
    tests++;
    if (b0.cfg_err !== 1'b0 || obs !== expv) begin fails++; $display("FAIL good_reload: got %h expected %h", obs, expv); end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] s;
    s = 4'b1011;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 14'd0) begin fails++; $display("FAIL midreset_outputs: got %h expected %h", obs, 14'd0); end
    #2 rst_n = 1'b1;
    model_reset();
    send_bit(1'b1, 1'b0);
    tests++;
    if (b0.detected !== 1'b0 || obs !== expv) begin fails++; $display("FAIL midreset_first: got %h expected %h", obs, expv); end
    for (int i = 0; i < 4; i++) begin
      send_bit(s[3-i], 1'b0);
      tests++;
      if (b0.detected !== (i == 3) || obs !== expv) begin
        fails++; $display("FAIL midreset_bit%0d: got %h expected %h", i+1, obs, expv);
      end
    end
    tests++;
    if (b0.match_count !== 8'd1) begin fails++; $display("FAIL midreset_count: got %0d expected 1", b0.match_count); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)
        cycle(1'b1, 8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
      else
        cycle(1'b0, 8'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
              ($urandom_range(0, 49) == 0));
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL random cyc%0d: got %h expected %h", i, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_default_1011();
    test_load_overlap();
    test_valid_gaps();
    test_saturation();
    test_bad_cfg();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
